// File: rtl/mips_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// word geometry and capacity helpers.
package mips_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 32'd4;
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 32'd1);
    localparam int unsigned DEFAULT_ADDR_W = 32'd8;
    localparam int unsigned IMEM_WORDS     = 32'd1 << DEFAULT_ADDR_W;

    // Capacity in 32-bit words for a given word-address width.
    function automatic int unsigned imem_words(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream. The first byte of a
// word lands in [31:24]; a byte flagged last completes the word early with
// the unfilled low bytes reading as zero.
module byte_word_packer
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  idx_r;
    logic [23:0] shreg_r;
    logic [31:0] word_s;
    logic        word_done_s;

    // Merge the incoming byte into its slot and flag a completed word.
    always_comb begin
        word_s = 32'h0000_0000;
        case (idx_r)
            2'd0:    word_s = {byte_data, 24'h00_0000};
            2'd1:    word_s = {shreg_r[23:16], byte_data, 16'h0000};
            2'd2:    word_s = {shreg_r[23:8], byte_data, 8'h00};
            2'd3:    word_s = {shreg_r, byte_data};
            default: word_s = 32'h0000_0000;
        endcase
        word_done_s = byte_valid && (byte_last || (idx_r == LAST_BYTE_IDX));
    end

    // Byte index and partial-word storage; both restart after each word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_r   <= 2'd0;
            shreg_r <= 24'h00_0000;
        end else if (clear) begin
            idx_r   <= 2'd0;
            shreg_r <= 24'h00_0000;
        end else if (word_done_s) begin
            idx_r   <= 2'd0;
            shreg_r <= 24'h00_0000;
        end else if (byte_valid) begin
            idx_r   <= idx_r + 2'd1;
            shreg_r <= word_s[31:8];
        end else begin
            idx_r   <= idx_r;
            shreg_r <= shreg_r;
        end
    end

    assign word_done = word_done_s;
    assign word      = word_s;

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream and keeps the CPU in reset
// until the whole image has been written. Writes stop at capacity; later
// bytes are swallowed and flagged as overflow.
module imem_loader
    import mips_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]   WORDS_C  = (ADDR_W + 1)'(imem_words(ADDR_W));
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_e            state_r, state_s;
    logic              s_ready_r, s_ready_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]       mem_wdata_r, mem_wdata_s;
    logic              cpu_reset_r, cpu_reset_s;
    logic              done_r, done_s;
    logic              error_r, error_s;
    logic [ADDR_W:0]   word_count_r, word_count_s;

    logic              accept_s;
    logic              start_ok_s;
    logic              overflow_s;
    logic [ADDR_W:0]   count_eff_s;
    logic              word_done_s;
    logic [31:0]       word_s;

    // Handshake qualification; the count includes a write still in flight so
    // that a byte arriving right after the final word is seen as overflow.
    always_comb begin
        accept_s    = s_valid && s_ready_r;
        start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE));
        count_eff_s = word_count_r + {{ADDR_W{1'b0}}, mem_we_r};
        overflow_s  = (count_eff_s == WORDS_C);
    end

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok_s),
        .byte_valid (accept_s && !overflow_s),
        .byte_data  (s_data),
        .byte_last  (s_last),
        .word_done  (word_done_s),
        .word       (word_s)
    );

    // Next-state and next-output logic; address and count advance the cycle
    // after each write, the address saturating at the top word.
    always_comb begin
        state_s      = state_r;
        s_ready_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_wdata_s  = mem_wdata_r;
        cpu_reset_s  = cpu_reset_r;
        done_s       = done_r;
        error_s      = error_r;
        word_count_s = count_eff_s;
        if (mem_we_r && (mem_addr_r != ADDR_MAX)) begin
            mem_addr_s = mem_addr_r + ADDR_W'(1);
        end else begin
            mem_addr_s = mem_addr_r;
        end

        case (state_r)
            IDLE, DONE: begin
                if (start_ok_s) begin
                    state_s      = LOAD;
                    s_ready_s    = 1'b1;
                    cpu_reset_s  = 1'b1;
                    done_s       = 1'b0;
                    error_s      = 1'b0;
                    mem_addr_s   = {ADDR_W{1'b0}};
                    word_count_s = {(ADDR_W + 1){1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                s_ready_s = 1'b1;
                if (accept_s) begin
                    if (overflow_s) begin
                        error_s = 1'b1;
                    end else if (word_done_s) begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = word_s;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    if (s_last) begin
                        state_s   = DRAIN;
                        s_ready_s = 1'b0;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            DRAIN: begin
                state_s     = DONE;
                done_s      = 1'b1;
                cpu_reset_s = 1'b0;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            s_ready_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 32'h0000_0000;
            cpu_reset_r  <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            word_count_r <= {(ADDR_W + 1){1'b0}};
        end else begin
            state_r      <= state_s;
            s_ready_r    <= s_ready_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            cpu_reset_r  <= cpu_reset_s;
            done_r       <= done_s;
            error_r      <= error_s;
            word_count_r <= word_count_s;
        end
    end

    assign s_ready    = s_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign cpu_reset  = cpu_reset_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Drives two loaders (256-word and 4-word) with the same byte stream and
// checks both against a transaction-level model of the expected image.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;

    logic        r0, we0, cr0, dn0, er0;
    logic [7:0]  a0;
    logic [31:0] wd0;
    logic [8:0]  wc0;
    logic        r1, we1, cr1, dn1, er1;
    logic [1:0]  a1;
    logic [31:0] wd1;
    logic [2:0]  wc1;

    imem_loader #(.ADDR_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_last(s_last), .s_ready(r0), .mem_we(we0),
        .mem_addr(a0), .mem_wdata(wd0), .cpu_reset(cr0), .done(dn0),
        .error(er0), .word_count(wc0)
    );

    imem_loader #(.ADDR_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_last(s_last), .s_ready(r1), .mem_we(we1),
        .mem_addr(a1), .mem_wdata(wd1), .cpu_reset(cr1), .done(dn1),
        .error(er1), .word_count(wc1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a;
        logic [31:0] d;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    bit          mon_on = 1'b0;
    bit          exp_ready = 1'b0;
    bit          exp_done = 1'b0;
    int          cap [2] = '{256, 4};
    int          mwords [2];
    bit          merr [2];
    int          nb [2];
    logic [31:0] acc [2];
    wr_t         q0 [$];
    wr_t         q1 [$];
    bit          prev_we [2];
    int          prev_a [2];
    logic [31:0] last_wd [2];
    int          nwr [2];
    logic [7:0]  img [$];

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            mwords[d] = 0;
            merr[d]   = 1'b0;
            nb[d]     = 0;
            acc[d]    = 32'h0;
            nwr[d]    = 0;
        end
    endtask

    // One accepted byte: pack big-endian, emit a write per full or last word.
    task automatic model_accept(input logic [7:0] b, input bit last);
        wr_t e;
        for (int d = 0; d < 2; d++) begin
            if (mwords[d] >= cap[d]) begin
                merr[d] = 1'b1;
            end else begin
                acc[d] = acc[d] | (32'(b) << (24 - 8 * nb[d]));
                nb[d]++;
                if (nb[d] == 4 || last) begin
                    e.a = mwords[d];
                    e.d = acc[d];
                    if (d == 0) q0.push_back(e);
                    else q1.push_back(e);
                    mwords[d]++;
                    acc[d] = 32'h0;
                    nb[d]  = 0;
                end
            end
        end
    endtask

    task automatic mon(input int d, input logic rdy, input logic we, input int a,
                       input logic [31:0] wd, input logic cr, input logic dn);
        wr_t e;
        chk("s_ready", d, 64'(rdy), 64'(exp_ready));
        chk("done", d, 64'(dn), 64'(exp_done));
        chk("cpu_reset", d, 64'(cr), 64'(!exp_done));
        if (we) begin
            if (prev_we[d]) chk("b2b_addr_step", d, 64'(a), 64'(prev_a[d] + 1));
            checks++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL spurious_write[dut%0d] got addr %0h data %0h expected no write", d, a, wd);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("wr_addr", d, 64'(a), 64'(e.a));
                chk("wr_data", d, 64'(wd), 64'(e.d));
            end
            last_wd[d] = wd;
            nwr[d]++;
        end
        prev_we[d] = we;
        prev_a[d]  = a;
    endtask

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, r0, we0, int'(a0), wd0, cr0, dn0);
            mon(1, r1, we1, int'(a1), wd1, cr1, dn1);
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        chk("pending_q", 0, 64'(q0.size()), 64'd0);
        chk("pending_q", 1, 64'(q1.size()), 64'd0);
        q0.delete();
        q1.delete();
        exp_ready = 1'b0;
        exp_done  = 1'b0;
        model_clear();
        #1;
        mon_on = 1'b1;
        chk("rst_we", 0, 64'(we0), 64'd0);   chk("rst_we", 1, 64'(we1), 64'd0);
        chk("rst_addr", 0, 64'(a0), 64'd0);  chk("rst_addr", 1, 64'(a1), 64'd0);
        chk("rst_wdata", 0, 64'(wd0), 64'd0); chk("rst_wdata", 1, 64'(wd1), 64'd0);
        chk("rst_ready", 0, 64'(r0), 64'd0); chk("rst_ready", 1, 64'(r1), 64'd0);
        chk("rst_err", 0, 64'(er0), 64'd0);  chk("rst_err", 1, 64'(er1), 64'd0);
        chk("rst_wc", 0, 64'(wc0), 64'd0);   chk("rst_wc", 1, 64'(wc1), 64'd0);
        chk("rst_cpu", 0, 64'(cr0), 64'd1);  chk("rst_cpu", 1, 64'(cr1), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        model_clear();
        #1;
        start = 1'b0;
        chk("start_err", 0, 64'(er0), 64'd0); chk("start_err", 1, 64'(er1), 64'd0);
        chk("start_wc", 0, 64'(wc0), 64'd0);  chk("start_wc", 1, 64'(wc1), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit gap, input bit st);
        bit ok = 1'b0;
        if (gap) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_data  = b;
        s_last  = last;
        s_valid = 1'b1;
        start   = st;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk);
            if (exp_ready) begin
                ok = 1'b1;
                model_accept(b, last);
                if (last) exp_ready = 1'b0;
            end
            #1;
            start = 1'b0;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL byte_timeout got no acceptance expected acceptance of %0h", b);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_load();
        @(posedge clk);
        exp_done = 1'b1;
        #1;
        chk("left_q", 0, 64'(q0.size()), 64'd0);
        chk("left_q", 1, 64'(q1.size()), 64'd0);
        chk("end_wc", 0, 64'(wc0), 64'(mwords[0]));
        chk("end_wc", 1, 64'(wc1), 64'(mwords[1]));
        chk("end_err", 0, 64'(er0), 64'(merr[0]));
        chk("end_err", 1, 64'(er1), 64'(merr[1]));
        chk("end_addr", 0, 64'(a0), 64'((mwords[0] == cap[0]) ? cap[0] - 1 : mwords[0]));
        chk("end_addr", 1, 64'(a1), 64'((mwords[1] == cap[1]) ? cap[1] - 1 : mwords[1]));
    endtask

    // mode: 0 = s_valid held, 1 = gap before every byte, 2 = random gaps.
    task automatic run_load(input int mode, input bit stray_start);
        bit gap;
        do_start();
        for (int i = 0; i < img.size(); i++) begin
            gap = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_byte(img[i], i == img.size() - 1, gap, stray_start && (i == 2));
        end
        finish_load();
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        apply_reset();

        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'h00, 8'h01};
        run_load(0, 1'b0);
        chk("t1_word1", 0, 64'(last_wd[0]), 64'h2129_0001);
        chk("t1_nwr", 0, 64'(nwr[0]), 64'd2);
        chk("t1_wc", 0, 64'(wc0), 64'd2);

        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        run_load(0, 1'b0);
        chk("t2_word1", 0, 64'(last_wd[0]), 64'h1122_0000);
        chk("t2_nwr", 0, 64'(nwr[0]), 64'd2);
        chk("t2_err", 0, 64'(er0), 64'd0);

        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'h00, 8'h01};
        run_load(1, 1'b0);
        chk("t3_word1", 0, 64'(last_wd[0]), 64'h2129_0001);

        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(i + 1));
        run_load(0, 1'b0);
        chk("t4_wc", 1, 64'(wc1), 64'd4);
        chk("t4_err", 1, 64'(er1), 64'd1);
        chk("t4_nwr", 1, 64'(nwr[1]), 64'd4);
        chk("t4_addr", 1, 64'(a1), 64'd3);
        chk("t4_word3", 1, 64'(last_wd[1]), 64'h0d0e_0f10);

        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_load(0, 1'b0);
        chk("t6_word0", 1, 64'(last_wd[1]), 64'h0);
        chk("t6_err", 1, 64'(er1), 64'd0);

        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'h00, 8'h01};
        do_start();
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0, 1'b0, 1'b0);
        apply_reset();
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(0, 1'b0);
        chk("t5_word0", 0, 64'(last_wd[0]), 64'hDEAD_BEEF);
        chk("t5_nwr", 0, 64'(nwr[0]), 64'd1);

        for (int n = 0; n < 8; n++) begin
            img.delete();
            for (int i = 0, len = $urandom_range(1, 24); i < len; i++)
                img.push_back(8'($urandom_range(0, 255)));
            run_load(2, (n % 2) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the CPU's instruction-memory read port: fills imem from a byte stream at run time instead of a simulation-only hex preload.
- Holds the pipelined CPU in reset until the program image is fully written, then releases it.
- Sits between a host byte source (UART/debug bridge) and the imem write port. It drives the CPU reset line.

Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2**ADDR_W 32-bit words.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_last  in  1  final byte of the image; qualified by s_valid.
- s_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  imem write strobe, one cycle per word.
- mem_addr  out  ADDR_W  imem word address.
- mem_wdata  out  32  imem write data.
- cpu_reset  out  1  active-high reset to the CPU.
- done  out  1  image loaded; CPU released.
- error  out  1  sticky overflow flag for the current load.
- word_count  out  ADDR_W+1  words written in the current load.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0, s_ready=0, done=0, error=0, word_count=0.
  - cpu_reset=1.
  - Internal byte index=0, shift register=0.
  - Reset mid-load abandons the load; words already written stay in imem.
- Handshake: a byte transfers at an edge where s_valid && s_ready. s_ready is 1 only in LOAD and is a registered output. s_data and s_last must stay stable while s_valid=1 and s_ready=0.
- Packing:
  - Big-endian: the first byte goes to [31:24], the fourth to [7:0], matching hex word text order.
  - A 2-bit byte index wraps 3->0.
- States:
  - IDLE: cpu_reset=1. start -> LOAD; at that edge word_count, mem_addr, error and byte index clear.
  - LOAD: s_ready=1.
    - When a word completes at edge N (4th byte accepted, or a byte with s_last), mem_we=1, mem_wdata=word and mem_addr=current address are registered at edge N. imem captures the word at edge N+1.
    - At edge N+1, mem_addr and word_count increment.
    - A byte with s_last completes a partial word: the unfilled low bytes are 0x00. The state then goes to DRAIN and s_ready=0 from edge N.
  - DRAIN: one cycle. mem_we stays 1 only for the final write, then 0. Next state is DONE.
  - DONE: done=1, cpu_reset=0; both change at the edge that ends DRAIN. start -> LOAD, which sets cpu_reset=1 and done=0 at that edge.
- mem_we is high for exactly one cycle per completed word and never two cycles for the same address.
- Overflow:
  - Bytes accepted when word_count==2**ADDR_W set error=1 (sticky until the next start or reset) and are dropped.
  - No write occurs and mem_addr does not wrap.
  - Acceptance continues until s_last, then DRAIN/DONE with no write.
- Simultaneous events:
  - start during LOAD or DRAIN is ignored.
  - start and reset together: reset wins.
- The loader does not hold or drop bytes across a word boundary: the 4th byte of word k and the 1st byte of word k+1 can transfer on consecutive cycles, giving back-to-back mem_we pulses to consecutive addresses.

Decomposition:
- Shared package mips_loader_pkg holds:
  - state encoding constants (IDLE, LOAD, DRAIN, DONE);
  - BYTES_PER_WORD=4;
  - localparam IMEM_WORDS derived from ADDR_W.
- One natural sub-module, byte_word_packer: the byte index, 32-bit shift register and the word-complete/padded-word outputs.
- FSM, address and count logic stay in imem_loader.

Test Plan:
- Load 8 bytes 20 08 00 05 21 29 00 01 with s_valid held high -> two mem_we pulses: addr 0 = 0x20080005, addr 1 = 0x21290001. word_count=2, done=1, cpu_reset falls on the same edge as done rises.
- Load 6 bytes AA BB CC DD 11 22 (last on 0x22) -> addr 1 = 0x11220000, exactly two writes, error=0.
- Same 8-byte image with s_valid toggling every other cycle -> identical writes, no duplicate or dropped bytes, s_ready never high outside LOAD.
- ADDR_W=2, 20-byte image -> 4 writes (addr 0..3), last 4 bytes dropped, error=1, word_count=4, done=1.
- Pull reset low after 5 bytes, then release and start a 4-byte load -> all outputs at reset values, then a single write to addr 0, byte index restarted at 0.
- After done, pulse start and load 4 bytes 00 00 00 00 -> cpu_reset=1 and done=0 at the start edge, error cleared, addr 0 rewritten with 0x00000000, done=1 again.
